// File: rtl/bram_ring_ctrl.sv
// bram_ring_ctrl: one-writer / two-reader circular buffer controller for a BRAM
// with one write port and two asynchronous read ports.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, flush        control pulses (IDLE->RUN, RUN->FLUSH->RUN)
//   en_a, en_b          reader enables; a disabled reader holds no data
//   s_valid/s_data/s_ready            source stream
//   a_valid/a_data/a_ready, b_*       reader streams
//   level_a, level_b    per-reader occupancy (0..DEPTH)
//   ram_*               BRAM write port and two asynchronous read ports
//   ovf_cnt             saturating count of stalled source cycles, only present
//                       when the macro RING_CTRL_OVF_CNT_EN is defined
//
// The writer is throttled by the fullest enabled reader.

module bram_ring_ctrl #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     flush,
    input  logic                     en_a,
    input  logic                     en_b,
    input  logic                     s_valid,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic                     s_ready,
    output logic                     a_valid,
    output logic [DATA_WIDTH-1:0]    a_data,
    input  logic                     a_ready,
    output logic                     b_valid,
    output logic [DATA_WIDTH-1:0]    b_data,
    input  logic                     b_ready,
    output logic [ADDRESS_WIDTH:0]   level_a,
    output logic [ADDRESS_WIDTH:0]   level_b,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr_a,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data_a,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr_b,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data_b
`ifdef RING_CTRL_OVF_CNT_EN
    ,
    output logic [15:0]              ovf_cnt
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int unsigned LVL_W = ADDRESS_WIDTH + 1;
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_a_q, rd_ptr_a_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_b_q, rd_ptr_b_d;
    logic [LVL_W-1:0]         level_a_q, level_a_d;
    logic [LVL_W-1:0]         level_b_q, level_b_d;

    logic run;
    logic pop_a, pop_b;
    logic room_a, room_b;
    logic wr_en, pop_a_en, pop_b_en;
    logic clear;

    always_comb begin
        run     = (state_q == StRun);
        a_valid = run & en_a & (level_a_q != '0);
        b_valid = run & en_b & (level_b_q != '0);
        pop_a   = a_valid & a_ready;
        pop_b   = b_valid & b_ready;
        // A pop in this cycle frees a slot, so a full reader does not block the writer.
        room_a  = ~en_a | (level_a_q != LEVEL_FULL) | pop_a;
        room_b  = ~en_b | (level_b_q != LEVEL_FULL) | pop_b;
        s_ready = run & room_a & room_b;
        // A flush accepted in RUN drops any same-cycle transfer.
        wr_en    = s_valid & s_ready & ~flush;
        pop_a_en = pop_a & ~flush;
        pop_b_en = pop_b & ~flush;
        clear    = (run & flush) | (state_q == StFlush);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (flush) state_d = StFlush;
            StFlush: state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(wr_en);

        if (en_a) begin
            rd_ptr_a_d = rd_ptr_a_q + ADDRESS_WIDTH'(pop_a_en);
            level_a_d  = level_a_q + LVL_W'(wr_en) - LVL_W'(pop_a_en);
        end else begin
            // Follow the writer so re-enabling starts empty with no stale data.
            rd_ptr_a_d = wr_ptr_d;
            level_a_d  = '0;
        end

        if (en_b) begin
            rd_ptr_b_d = rd_ptr_b_q + ADDRESS_WIDTH'(pop_b_en);
            level_b_d  = level_b_q + LVL_W'(wr_en) - LVL_W'(pop_b_en);
        end else begin
            rd_ptr_b_d = wr_ptr_d;
            level_b_d  = '0;
        end

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_a_d = '0;
            rd_ptr_b_d = '0;
            level_a_d  = '0;
            level_b_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_a_q <= '0;
            rd_ptr_b_q <= '0;
            level_a_q  <= '0;
            level_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_a_q <= rd_ptr_a_d;
            rd_ptr_b_q <= rd_ptr_b_d;
            level_a_q  <= level_a_d;
            level_b_q  <= level_b_d;
        end
    end

    always_comb begin
        ram_we        = wr_en;
        ram_wr_addr   = wr_ptr_q;
        ram_wr_data   = s_data;
        ram_rd_addr_a = rd_ptr_a_q;
        ram_rd_addr_b = rd_ptr_b_q;
        a_data        = ram_rd_data_a;
        b_data        = ram_rd_data_b;
        level_a       = level_a_q;
        level_b       = level_b_q;
    end

`ifdef RING_CTRL_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (run & flush) begin
            ovf_cnt_d = '0;
        end else if (run & s_valid & ~s_ready & (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_bram_ring_ctrl.sv
module tb_bram_ring_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, flush, en_a, en_b;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [DW-1:0] a_data, b_data;
    logic [AW:0]   level_a, level_b;
    logic          ram_we;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr_a, ram_rd_addr_b;
    logic [DW-1:0] ram_wr_data, ram_rd_data_a, ram_rd_data_b;
`ifdef RING_CTRL_OVF_CNT_EN
    logic [15:0]   ovf_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] exp_d;

    always #5 clk = ~clk;

    bram_ring_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .en_a(en_a), .en_b(en_b),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .level_a(level_a), .level_b(level_b),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr_a(ram_rd_addr_a), .ram_rd_data_a(ram_rd_data_a),
        .ram_rd_addr_b(ram_rd_addr_b), .ram_rd_data_b(ram_rd_data_b)
`ifdef RING_CTRL_OVF_CNT_EN
        , .ovf_cnt(ovf_cnt)
`endif
    );

    // BRAM model: synchronous write, asynchronous reads.
    logic [DW-1:0] mem [4];
    always @(posedge clk) if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    assign ram_rd_data_a = mem[ram_rd_addr_a];
    assign ram_rd_data_b = mem[ram_rd_addr_b];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; flush = 0; en_a = 1; en_b = 1;
        s_valid = 1; s_data = 16'hDEAD; a_ready = 1; b_ready = 1;
        tick(); tick();
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if ({a_valid, b_valid} !== 2'b00) begin failures++; $display("FAIL reset_valids got=%b exp=00", {a_valid, b_valid}); end
        checks++; if (level_a !== 3'd0 || level_b !== 3'd0) begin failures++; $display("FAIL reset_levels got=%0d/%0d exp=0/0", level_a, level_b); end
        s_valid = 0; a_ready = 0; b_ready = 0;
        rst_n = 1'b1;
        tick();
        // IDLE still blocks the source after reset release.
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL idle_s_ready got=%b exp=0", s_ready); end
    endtask

    task automatic test_fill();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = 16'h0011 * DW'(i + 1); #1;
            checks++; if (s_ready !== 1'b1 || ram_we !== 1'b1) begin failures++; $display("FAIL fill_accept[%0d] got=%b%b exp=11", i, s_ready, ram_we); end
            checks++; if (ram_wr_addr !== AW'(i)) begin failures++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, ram_wr_addr, i); end
            qa.push_back(s_data); qb.push_back(s_data);
            tick();
        end
        s_valid = 1; s_data = 16'h0055; #1;
        checks++; if (s_ready !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%b%b exp=00", s_ready, ram_we); end
        s_valid = 0; #1;
        checks++; if (level_a !== 3'd4 || level_b !== 3'd4) begin failures++; $display("FAIL full_levels got=%0d/%0d exp=4/4", level_a, level_b); end
        checks++; if (a_data !== qa[0]) begin failures++; $display("FAIL full_a_data got=%h exp=%h", a_data, qa[0]); end
        checks++; if (b_data !== qb[0]) begin failures++; $display("FAIL full_b_data got=%h exp=%h", b_data, qb[0]); end
    endtask

    task automatic test_drain_full();
        for (int i = 0; i < 4; i++) begin
            a_ready = 1; #1;
            exp_d = qa.pop_front();
            checks++; if (a_valid !== 1'b1 || a_data !== exp_d) begin failures++; $display("FAIL drain_a[%0d] got=%b/%h exp=1/%h", i, a_valid, a_data, exp_d); end
            checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL drain_s_ready[%0d] got=%b exp=0", i, s_ready); end
            tick();
        end
        a_ready = 0; #1;
        checks++; if (level_a !== 3'd0 || level_b !== 3'd4 || a_valid !== 1'b0) begin failures++; $display("FAIL drain_levels got=%0d/%0d/%b exp=0/4/0", level_a, level_b, a_valid); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL b_full_s_ready got=%b exp=0", s_ready); end
        b_ready = 1; #1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL pop_frees_s_ready got=%b exp=1", s_ready); end
        exp_d = qb.pop_front();
        checks++; if (b_data !== exp_d) begin failures++; $display("FAIL drain_b got=%h exp=%h", b_data, exp_d); end
        tick(); b_ready = 0; #1;
        checks++; if (level_b !== 3'd3) begin failures++; $display("FAIL level_b_after_pop got=%0d exp=3", level_b); end
    endtask

    task automatic test_simul_wr_pop();
        en_b = 0; tick(); qb.delete();
        checks++; if (level_b !== 3'd0 || b_valid !== 1'b0) begin failures++; $display("FAIL disable_b got=%0d/%b exp=0/0", level_b, b_valid); end
        for (int i = 1; i <= 2; i++) begin
            s_valid = 1; s_data = 16'h0101 * DW'(i); qa.push_back(s_data); tick();
        end
        s_valid = 1; s_data = 16'h0303; a_ready = 1; #1;
        exp_d = qa.pop_front();
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL simul_ram_we got=%b exp=1", ram_we); end
        checks++; if (a_data !== exp_d) begin failures++; $display("FAIL simul_a_data got=%h exp=%h", a_data, exp_d); end
        qa.push_back(s_data);
        tick(); s_valid = 0; a_ready = 0; #1;
        checks++; if (level_a !== 3'd2) begin failures++; $display("FAIL simul_level got=%0d exp=2", level_a); end
        checks++; if (a_data !== qa[0]) begin failures++; $display("FAIL simul_next_data got=%h exp=%h", a_data, qa[0]); end
    endtask

    task automatic test_disabled_reader();
        for (int i = 0; i < 10; i++) begin
            s_valid = 1; s_data = 16'h0A00 + DW'(i); a_ready = 1; #1;
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL freerun_s_ready[%0d] got=%b exp=1", i, s_ready); end
            exp_d = qa.pop_front();
            checks++; if (a_valid !== 1'b1 || a_data !== exp_d) begin failures++; $display("FAIL freerun_a[%0d] got=%b/%h exp=1/%h", i, a_valid, a_data, exp_d); end
            qa.push_back(s_data);
            tick();
        end
        s_valid = 0; a_ready = 0; en_b = 1; #1;
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL reenable_b_valid got=%b exp=0", b_valid); end
        tick();
        checks++; if (b_valid !== 1'b0 || level_b !== 3'd0) begin failures++; $display("FAIL reenable_b_idle got=%b/%0d exp=0/0", b_valid, level_b); end
        s_valid = 1; s_data = 16'h0B0B; qa.push_back(s_data); qb.push_back(s_data);
        tick(); s_valid = 0; #1;
        checks++; if (b_valid !== 1'b1 || b_data !== 16'h0B0B) begin failures++; $display("FAIL reenable_b_data got=%b/%h exp=1/0b0b", b_valid, b_data); end
        for (int i = 0; i < 4 && (qa.size() > 0 || qb.size() > 0); i++) begin
            a_ready = (qa.size() > 0); b_ready = (qb.size() > 0); #1;
            if (a_ready) begin
                exp_d = qa.pop_front();
                checks++; if (a_data !== exp_d) begin failures++; $display("FAIL empty_a[%0d] got=%h exp=%h", i, a_data, exp_d); end
            end
            if (b_ready) begin
                exp_d = qb.pop_front();
                checks++; if (b_data !== exp_d) begin failures++; $display("FAIL empty_b[%0d] got=%h exp=%h", i, b_data, exp_d); end
            end
            tick();
        end
        a_ready = 0; b_ready = 0; #1;
        checks++; if (level_a !== 3'd0 || level_b !== 3'd0) begin failures++; $display("FAIL emptied_levels got=%0d/%0d exp=0/0", level_a, level_b); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_data = 16'h0C00 + DW'(i); tick();
        end
        s_valid = 1; s_data = 16'h0CFF; flush = 1; #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL flush_drops_write got=%b exp=0", ram_we); end
        tick(); flush = 0; s_valid = 0; #1;
        checks++; if (level_a !== 3'd0 || level_b !== 3'd0) begin failures++; $display("FAIL flush_levels got=%0d/%0d exp=0/0", level_a, level_b); end
        checks++; if ({a_valid, b_valid, s_ready} !== 3'b000) begin failures++; $display("FAIL flush_outputs got=%b exp=000", {a_valid, b_valid, s_ready}); end
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL post_flush_run got=%b exp=1", s_ready); end
        qa.delete(); qb.delete();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) begin
            s_valid = 1; s_data = 16'h0500 + DW'(i); #1;
            qa.push_back(s_data); qb.push_back(s_data);
            checks++; if (ram_we !== 1'b1 || ram_wr_addr !== AW'(i % 4)) begin failures++; $display("FAIL wrap_addr[%0d] got=%b/%0d exp=1/%0d", i, ram_we, ram_wr_addr, i % 4); end
            tick(); s_valid = 0; a_ready = 1; b_ready = 1; #1;
            exp_d = qa.pop_front();
            checks++; if (a_valid !== 1'b1 || a_data !== exp_d) begin failures++; $display("FAIL wrap_a[%0d] got=%b/%h exp=1/%h", i, a_valid, a_data, exp_d); end
            exp_d = qb.pop_front();
            checks++; if (b_valid !== 1'b1 || b_data !== exp_d) begin failures++; $display("FAIL wrap_b[%0d] got=%b/%h exp=1/%h", i, b_valid, b_data, exp_d); end
            tick(); a_ready = 0; b_ready = 0;
        end
    endtask

`ifdef RING_CTRL_OVF_CNT_EN
    task automatic test_ovf_cnt();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = 16'h0D00 + DW'(i); tick();
        end
        for (int i = 0; i < 5; i++) tick();
        s_valid = 0; #1;
        checks++; if (ovf_cnt !== 16'd5) begin failures++; $display("FAIL ovf_cnt got=%0d exp=5", ovf_cnt); end
        flush = 1; tick(); flush = 0; #1;
        checks++; if (ovf_cnt !== 16'd0) begin failures++; $display("FAIL ovf_cnt_flush got=%0d exp=0", ovf_cnt); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain_full();
        test_simul_wr_pop();
        test_disabled_reader();
        test_flush();
        test_wrap();
`ifdef RING_CTRL_OVF_CNT_EN
        test_ovf_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
